// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: access sizes, FSM states and the IO region select.
package mem_arbiter_pkg;

   localparam logic [1:0] SIZE_W = 2'b00;
   localparam logic [1:0] SIZE_B = 2'b01;
   localparam logic [1:0] SIZE_H = 2'b10;

   localparam logic [1:0] IO_SEL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_READ  = 2'b01,
      ST_WRITE = 2'b10
   } arb_state_e;

   // Size 2'b11 falls into the default and is treated as a word.
   function automatic logic [2:0] byte_count(input logic [1:0] size);
      case (size)
         SIZE_B:  return 3'd1;
         SIZE_H:  return 3'd2;
         SIZE_W:  return 3'd4;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic io_stall(input logic [1:0] sel, input logic full);
      return full && (sel == IO_SEL);
   endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Per-transaction byte sequencer: drives the RAM address/data/write strobe and
// assembles read bytes little-endian into a word.
module mem_byte_seq
   import mem_arbiter_pkg::*;
#(
   parameter int AddrWidth = 32,
   parameter int IoSelHi   = 17,
   parameter int IoSelLo   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  arb_state_e           state,
   input  logic                 start,
   input  logic                 start_wr,
   input  logic [AddrWidth-1:0] start_addr,
   input  logic [31:0]          start_wdata,
   input  logic [2:0]           start_n,
   input  logic                 io_full,
   input  logic [7:0]           mem_din,
   output logic [AddrWidth-1:0] mem_a,
   output logic [7:0]           mem_dout,
   output logic                 mem_wr,
   output logic                 rd_fin,
   output logic                 wr_fin,
   output logic [31:0]          rd_word
);

   // rem_q: reads count down the edges left until done (N+1 at accept);
   // writes count the bytes still to go after the one on the bus.
   logic [2:0]           rem_q;
   logic [2:0]           n_q;
   logic [31:0]          acc_q;
   logic [31:0]          wdata_q;
   logic [1:0]           lane;
   logic [AddrWidth-1:0] next_a;

   assign next_a = mem_a + AddrWidth'(1);
   assign lane   = n_q[1:0] - rem_q[1:0];
   assign rd_fin = (state == ST_READ) && (rem_q == 3'd1);
   assign wr_fin = (state == ST_WRITE) && mem_wr && (rem_q == 3'd0);

   always_comb begin
      rd_word             = acc_q;
      rd_word[8*lane +: 8] = mem_din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_a    <= '0;
         mem_dout <= '0;
         mem_wr   <= 1'b0;
         rem_q    <= '0;
         n_q      <= '0;
         acc_q    <= '0;
         wdata_q  <= '0;
      end else if (start) begin
         mem_a   <= start_addr;
         n_q     <= start_n;
         acc_q   <= '0;
         wdata_q <= {8'h00, start_wdata[31:8]};
         if (start_wr) begin
            rem_q    <= start_n - 3'd1;
            mem_dout <= start_wdata[7:0];
            mem_wr   <= !io_stall(start_addr[IoSelHi:IoSelLo], io_full);
         end else begin
            rem_q  <= start_n + 3'd1;
            mem_wr <= 1'b0;
         end
      end else if (state == ST_READ) begin
         if (rem_q != 3'd0) rem_q <= rem_q - 3'd1;
         if (rem_q >= 3'd3) mem_a <= next_a;
         if (rem_q <= n_q)  acc_q <= rd_word;
      end else if (state == ST_WRITE) begin
         if (!mem_wr) begin
            // stalled byte: retry the same address/data once the IO buffer drains
            mem_wr <= !io_stall(mem_a[IoSelHi:IoSelLo], io_full);
         end else if (rem_q == 3'd0) begin
            mem_wr <= 1'b0;
         end else begin
            mem_a    <= next_a;
            mem_dout <= wdata_q[7:0];
            wdata_q  <= {8'h00, wdata_q[31:8]};
            rem_q    <= rem_q - 3'd1;
            mem_wr   <= !io_stall(next_a[IoSelHi:IoSelLo], io_full);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port byte RAM arbiter between the instruction fetcher and the store/load buffer.
//
//   state    | meaning
//   ST_IDLE  | waiting; accepts SLB (priority) or IF when flush is low
//   ST_READ  | serial byte read in flight; flush abandons it
//   ST_WRITE | serial byte store in flight; runs to completion, stalls on full IO buffer
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AddrWidth = 32,
   parameter int IoSelHi   = 17,
   parameter int IoSelLo   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 if_valid,
   input  logic [AddrWidth-1:0] if_addr,
   output logic                 if_done,
   output logic [31:0]          if_rdata,
   input  logic                 slb_valid,
   input  logic                 slb_is_store,
   input  logic [1:0]           slb_size,
   input  logic [AddrWidth-1:0] slb_addr,
   input  logic [31:0]          slb_wdata,
   output logic                 slb_done,
   output logic [31:0]          slb_rdata,
   input  logic [7:0]           mem_din,
   output logic [7:0]           mem_dout,
   output logic [AddrWidth-1:0] mem_a,
   output logic                 mem_wr,
   input  logic                 io_buffer_full
);

   arb_state_e           state_q, state_d;
   logic                 owner_slb_q;
   logic                 start, start_wr, start_slb;
   logic [AddrWidth-1:0] start_addr;
   logic [2:0]           start_n;
   logic                 rd_fin, wr_fin, rd_ok;
   logic [31:0]          rd_word;
   logic                 slb_req, if_req;

   // a requester still seeing its done pulse has not had a chance to drop valid
   assign slb_req = slb_valid && !slb_done;
   assign if_req  = if_valid && !if_done;
   assign rd_ok   = rd_fin && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      start      = 1'b0;
      start_wr   = 1'b0;
      start_slb  = 1'b0;
      start_addr = slb_addr;
      start_n    = 3'd4;
      case (state_q)
         ST_IDLE: begin
            if (!flush) begin
               if (slb_req) begin
                  start     = 1'b1;
                  start_slb = 1'b1;
                  start_wr  = slb_is_store;
                  start_n   = byte_count(slb_size);
                  state_d   = slb_is_store ? ST_WRITE : ST_READ;
               end else if (if_req) begin
                  start      = 1'b1;
                  start_addr = if_addr;
                  state_d    = ST_READ;
               end
            end
         end
         ST_READ:  if (flush || rd_fin) state_d = ST_IDLE;
         ST_WRITE: if (wr_fin)          state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_slb_q <= 1'b0;
         if_done     <= 1'b0;
         slb_done    <= 1'b0;
         if_rdata    <= '0;
         slb_rdata   <= '0;
      end else begin
         if (start) owner_slb_q <= start_slb;
         if_done  <= rd_ok && !owner_slb_q;
         slb_done <= (rd_ok && owner_slb_q) || wr_fin;
         if (rd_ok && !owner_slb_q) if_rdata  <= rd_word;
         if (rd_ok && owner_slb_q)  slb_rdata <= rd_word;
      end
   end

   mem_byte_seq #(
      .AddrWidth (AddrWidth),
      .IoSelHi   (IoSelHi),
      .IoSelLo   (IoSelLo)
   ) u_seq (
      .clk         (clk),
      .rst         (rst),
      .state       (state_q),
      .start       (start),
      .start_wr    (start_wr),
      .start_addr  (start_addr),
      .start_wdata (slb_wdata),
      .start_n     (start_n),
      .io_full     (io_buffer_full),
      .mem_din     (mem_din),
      .mem_a       (mem_a),
      .mem_dout    (mem_dout),
      .mem_wr      (mem_wr),
      .rd_fin      (rd_fin),
      .wr_fin      (wr_fin),
      .rd_word     (rd_word)
   );

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory controller that shares the byte-wide RAM between the instruction fetcher (IF) and the store/load buffer (SLB).
- Serialises each word, half or byte access into per-byte RAM cycles.
- Assembles read data little-endian and applies back-pressure on IO writes.
- Sits between the fetcher/SLB and the top-level RAM/IO bus; answers a pipeline flush by abandoning reads.

Parameters:
- AddrWidth, 32, byte-address width.
- IoSelHi, 17, upper bit of the IO-region select field.
- IoSelLo, 16, lower bit of the IO-region select field; addr[IoSelHi:IoSelLo]==2'b11 marks the IO region.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  ROB exception/mispredict flush, synchronous
- if_valid  in  1  fetch request, held until if_done
- if_addr  in  AddrWidth  fetch address; always a word read
- if_done  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  32  fetched instruction
- slb_valid  in  1  SLB request, held until slb_done
- slb_is_store  in  1  1 = store, 0 = load
- slb_size  in  2  00 = word, 01 = byte, 10 = half; 11 is treated as word
- slb_addr  in  AddrWidth  access address
- slb_wdata  in  32  store data, low bytes used
- slb_done  out  1  one-cycle pulse; load data valid or store complete
- slb_rdata  out  32  load data, zero-extended raw bytes (SLB performs sign extension)
- mem_din  in  8  RAM read byte, valid one cycle after mem_a
- mem_dout  out  8  RAM write byte
- mem_a  out  AddrWidth  RAM address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  IO write buffer full

Behaviour:
- Reset (async): state IDLE; mem_a=0, mem_dout=0, mem_wr=0, if_done=0, slb_done=0, if_rdata=0, slb_rdata=0; counters cleared. Reset during a transaction aborts it immediately.
- All outputs are registered. States: IDLE, READ, WRITE.
- Byte count N: 4 for word, 2 for half, 1 for byte.
- Request accept happens only in IDLE with flush=0.
  - SLB has priority over IF; there is no preemption once a transaction has started.
  - A requester whose done is high in the current cycle has its valid ignored, so a held valid is not double-accepted.
- READ, accept edge E0: mem_a<=addr, mem_wr<=0.
  - Edges E1..E(N-1): mem_a<=addr+k.
  - Edges E2..E(N+1): capture mem_din into byte k-1 (byte 0 = lowest address → bits[7:0]).
  - Edge E(N+1): done<=1, rdata updated with the unused upper bytes zero, state<=IDLE.
  - Latency from accept edge to done: word 5 edges, half 3, byte 2.
- WRITE, accept edge E0: mem_a<=addr, mem_dout<=byte0, mem_wr<=1.
  - Each following edge advances to the next byte.
  - At the edge after the last byte is driven: mem_wr<=0, slb_done<=1, state<=IDLE.
  - Latency: byte 1 edge, half 2, word 4.
- IO stall: while io_buffer_full=1 and the current write address is in the IO region, hold the byte (mem_wr<=0, same mem_a/mem_dout) and do not advance. Resume when io_buffer_full drops.
- Flush:
  - In READ: next edge → IDLE, no done, mem_wr=0.
  - In WRITE: the store completes normally, because stores reach the arbiter only after commit.
  - In IDLE: no accept that cycle.
- Done pulses last exactly one cycle; rdata holds its value until the next done.
- Address increment wraps modulo 2^AddrWidth.
- if_done and slb_done are never high in the same cycle.

Decomposition:
- Shared parameters header (existing `parameters.v`) gains:
  - size encodings SIZE_W=2'b00, SIZE_B=2'b01, SIZE_H=2'b10;
  - state encodings;
  - IO region select value 2'b11.
- One sub-module is natural: mem_byte_seq, the per-transaction byte counter/address/data shifter. The top level keeps arbitration, flush handling and done routing.

Test Plan:
- IF word read at 0x00001000, RAM bytes 13,05,00,00 → mem_a sequence 1000..1003, if_done 5 edges after accept, if_rdata=0x00000513.
- SLB and IF request on the same cycle with SLB store word 0xDEADBEEF at 0x200 → four writes EF,BE,AD,DE at 0x200..0x203, slb_done at edge 4; IF accepted on the following edge.
- SLB load half at 0x1FE, RAM bytes 0x80,0xFF → slb_rdata=0x0000FF80, done 3 edges after accept.
- SLB store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for those cycles, then one write, slb_done one edge later.
- Flush asserted during the 2nd byte of an IF word read → no if_done, state IDLE next edge, a new SLB request is accepted the edge after.
- rst asserted mid-store → all outputs return to 0 immediately; a new request after rst is released completes normally.
